// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared states, opcodes and select encodings for the multicycle control unit.
package ctrl_pkg;
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BEQ, S_JAL
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRC_A_PC    = 2'b00;
    localparam logic [1:0] SRC_A_OLDPC = 2'b01;
    localparam logic [1:0] SRC_A_REG   = 2'b10;
    localparam logic [1:0] SRC_B_REG   = 2'b00;
    localparam logic [1:0] SRC_B_IMM   = 2'b01;
    localparam logic [1:0] SRC_B_FOUR  = 2'b10;
    localparam logic [1:0] RES_ALUOUT  = 2'b00;
    localparam logic [1:0] RES_MEM     = 2'b01;
    localparam logic [1:0] RES_ALU     = 2'b10;
endpackage

// File: rtl/alu_dec.sv
// alu_dec: maps alu_op and instruction funct fields to the ALU operation.
module alu_dec
    import ctrl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op5,
    output logic [2:0] alu_control
);
    always_comb begin
        alu_control = ALU_ADD;
        if (alu_op == ALUOP_SUB) begin
            alu_control = ALU_SUB;
        end else if (alu_op == ALUOP_FUNCT) begin
            // Immediate forms have op[5]=0, so addi never becomes sub.
            case (funct3)
                3'b000:  alu_control = (funct7b5 & op5) ? ALU_SUB : ALU_ADD;
                3'b010:  alu_control = ALU_SLT;
                3'b110:  alu_control = ALU_OR;
                3'b111:  alu_control = ALU_AND;
                default: alu_control = ALU_ADD;
            endcase
        end
    end
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore FSM sequencing fetch/decode/execute/memory/writeback
// for the multicycle RISC-V core.
module multicycle_ctrl
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic       ir_write,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic [2:0] alu_control,
    output logic       illegal_op
);
    state_t     state_q, state_d;
    logic       pc_update, branch;
    logic [1:0] alu_op;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: state_d = (op == OP_LW || op == OP_SW) ? S_MEMADR :
                                (op == OP_R)   ? S_EXECUTER :
                                (op == OP_I)   ? S_EXECUTEI :
                                (op == OP_BEQ) ? S_BEQ :
                                (op == OP_JAL) ? S_JAL : S_FETCH;
            S_MEMADR: state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD: state_d = S_MEMWB;
            S_EXECUTER, S_EXECUTEI, S_JAL: state_d = S_ALUWB;
            default:  state_d = S_FETCH;
        endcase
    end

    always_comb begin
        ir_write   = 1'b0;
        pc_update  = 1'b0;
        branch     = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = SRC_A_PC;
        alu_src_b  = SRC_B_REG;
        result_src = RES_ALUOUT;
        alu_op     = ALUOP_ADD;
        illegal_op = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_write   = 1'b1;
                pc_update  = 1'b1;
                alu_src_b  = SRC_B_FOUR;
                result_src = RES_ALU;
            end
            S_DECODE: begin
                alu_src_a  = SRC_A_OLDPC;
                alu_src_b  = SRC_B_IMM;
                illegal_op = !(op inside {OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL});
            end
            S_MEMADR: begin
                alu_src_a = SRC_A_REG;
                alu_src_b = SRC_B_IMM;
            end
            S_MEMREAD: adr_src = 1'b1;
            S_MEMWB: begin
                result_src = RES_MEM;
                reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
            end
            S_EXECUTER: begin
                alu_src_a = SRC_A_REG;
                alu_op    = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                alu_src_a = SRC_A_REG;
                alu_src_b = SRC_B_IMM;
                alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: reg_write = 1'b1;
            S_BEQ: begin
                alu_src_a = SRC_A_REG;
                alu_op    = ALUOP_SUB;
                branch    = 1'b1;
            end
            S_JAL: begin
                alu_src_a = SRC_A_OLDPC;
                alu_src_b = SRC_B_FOUR;
                pc_update = 1'b1;
            end
            default: ;
        endcase
    end

    assign pc_write = pc_update | (branch & zero);

    alu_dec u_alu_dec (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .op5         (op[5]),
        .alu_control (alu_control)
    );
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: table-driven per-cycle check of the control unit outputs,
// plus an asynchronous reset abort in the middle of a load.
module tb_multicycle_ctrl;
    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       ir_write, pc_write, adr_src, mem_write, reg_write, illegal_op;
    logic [1:0] alu_src_a, alu_src_b, result_src;
    logic [2:0] alu_control;
    logic [14:0] outs;

    multicycle_ctrl dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .ir_write(ir_write), .pc_write(pc_write), .adr_src(adr_src),
        .mem_write(mem_write), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .result_src(result_src), .alu_control(alu_control),
        .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    // {ir, pc, adr, mw, rw, a[2], b[2], rs[2], alu[3], ill}
    assign outs = {ir_write, pc_write, adr_src, mem_write, reg_write,
                   alu_src_a, alu_src_b, result_src, alu_control, illegal_op};

    localparam logic [14:0] E_F    = 15'b11000_00_10_10_000_0;
    localparam logic [14:0] E_D    = 15'b00000_01_01_00_000_0;
    localparam logic [14:0] E_DI   = 15'b00000_01_01_00_000_1;
    localparam logic [14:0] E_MA   = 15'b00000_10_01_00_000_0;
    localparam logic [14:0] E_MR   = 15'b00100_00_00_00_000_0;
    localparam logic [14:0] E_MWB  = 15'b00001_00_00_01_000_0;
    localparam logic [14:0] E_MW   = 15'b00110_00_00_00_000_0;
    localparam logic [14:0] E_RADD = 15'b00000_10_00_00_000_0;
    localparam logic [14:0] E_RSUB = 15'b00000_10_00_00_001_0;
    localparam logic [14:0] E_RAND = 15'b00000_10_00_00_010_0;
    localparam logic [14:0] E_ROR  = 15'b00000_10_00_00_011_0;
    localparam logic [14:0] E_IADD = 15'b00000_10_01_00_000_0;
    localparam logic [14:0] E_ISLT = 15'b00000_10_01_00_101_0;
    localparam logic [14:0] E_WB   = 15'b00001_00_00_00_000_0;
    localparam logic [14:0] E_BT   = 15'b01000_10_00_00_001_0;
    localparam logic [14:0] E_BF   = 15'b00000_10_00_00_001_0;
    localparam logic [14:0] E_J    = 15'b01000_01_10_00_000_0;

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
    localparam logic [6:0] IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111;
    localparam logic [6:0] BAD = 7'b1111111;

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic        z;
        logic [14:0] exp;
    } vec_t;

    vec_t        vecs[$];
    logic [14:0] exp_q[$];
    string       tag_q[$];
    int          n_vec = 0;
    int          n_err = 0;

    task automatic check();
        logic [14:0] e;
        string t;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL scoreboard empty: got %b required an entry", outs);
            return;
        end
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        n_vec++;
        if (outs !== e) begin
            n_err++;
            $display("FAIL %s: got %b required %b", t, outs, e);
        end
    endtask

    task automatic expect_now(input string t, input logic [14:0] e);
        exp_q.push_back(e);
        tag_q.push_back(t);
        check();
    endtask

    task automatic step(input string t, input logic [6:0] o, input logic [2:0] f3,
                        input logic f7, input logic z, input logic [14:0] e);
        op = o; funct3 = f3; funct7b5 = f7; zero = z;
        exp_q.push_back(e);
        tag_q.push_back(t);
        @(negedge clk);
        check();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs = '{
            '{LW, 3'b010, 1'b0, 1'b0, E_F},  '{LW, 3'b010, 1'b0, 1'b0, E_D},
            '{LW, 3'b010, 1'b0, 1'b0, E_MA}, '{LW, 3'b010, 1'b0, 1'b0, E_MR},
            '{LW, 3'b010, 1'b0, 1'b0, E_MWB},
            '{SW, 3'b010, 1'b0, 1'b1, E_F},  '{SW, 3'b010, 1'b0, 1'b1, E_D},
            '{SW, 3'b010, 1'b0, 1'b1, E_MA}, '{SW, 3'b010, 1'b0, 1'b1, E_MW},
            '{RT, 3'b000, 1'b1, 1'b0, E_F},  '{RT, 3'b000, 1'b1, 1'b0, E_D},
            '{RT, 3'b000, 1'b1, 1'b0, E_RSUB}, '{RT, 3'b000, 1'b1, 1'b0, E_WB},
            '{RT, 3'b000, 1'b0, 1'b0, E_F},  '{RT, 3'b000, 1'b0, 1'b0, E_D},
            '{RT, 3'b000, 1'b0, 1'b0, E_RADD}, '{RT, 3'b000, 1'b0, 1'b0, E_WB},
            '{RT, 3'b111, 1'b0, 1'b0, E_F},  '{RT, 3'b111, 1'b0, 1'b0, E_D},
            '{RT, 3'b111, 1'b0, 1'b0, E_RAND}, '{RT, 3'b111, 1'b0, 1'b0, E_WB},
            '{RT, 3'b110, 1'b0, 1'b0, E_F},  '{RT, 3'b110, 1'b0, 1'b0, E_D},
            '{RT, 3'b110, 1'b0, 1'b0, E_ROR},  '{RT, 3'b110, 1'b0, 1'b0, E_WB},
            '{RT, 3'b001, 1'b1, 1'b0, E_F},  '{RT, 3'b001, 1'b1, 1'b0, E_D},
            '{RT, 3'b001, 1'b1, 1'b0, E_RADD}, '{RT, 3'b001, 1'b1, 1'b0, E_WB},
            '{IT, 3'b000, 1'b1, 1'b0, E_F},  '{IT, 3'b000, 1'b1, 1'b0, E_D},
            '{IT, 3'b000, 1'b1, 1'b0, E_IADD}, '{IT, 3'b000, 1'b1, 1'b0, E_WB},
            '{IT, 3'b010, 1'b0, 1'b0, E_F},  '{IT, 3'b010, 1'b0, 1'b0, E_D},
            '{IT, 3'b010, 1'b0, 1'b0, E_ISLT}, '{IT, 3'b010, 1'b0, 1'b0, E_WB},
            '{BQ, 3'b000, 1'b0, 1'b1, E_F},  '{BQ, 3'b000, 1'b0, 1'b1, E_D},
            '{BQ, 3'b000, 1'b0, 1'b1, E_BT},
            '{BQ, 3'b000, 1'b0, 1'b0, E_F},  '{BQ, 3'b000, 1'b0, 1'b0, E_D},
            '{BQ, 3'b000, 1'b0, 1'b0, E_BF},
            '{JL, 3'b000, 1'b0, 1'b0, E_F},  '{JL, 3'b000, 1'b0, 1'b0, E_D},
            '{JL, 3'b000, 1'b0, 1'b0, E_J},  '{JL, 3'b000, 1'b0, 1'b0, E_WB},
            '{BAD, 3'b000, 1'b0, 1'b0, E_F}, '{BAD, 3'b000, 1'b0, 1'b0, E_DI},
            '{BAD, 3'b000, 1'b0, 1'b0, E_F}, '{LW, 3'b000, 1'b0, 1'b0, E_D}
        };
        reset = 1'b1; op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0; zero = 1'b0;
        #2;
        expect_now("reset_state", E_F);
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < vecs.size(); i++)
            step($sformatf("vec%0d", i), vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].z, vecs[i].exp);
        // Load aborted by reset while in MEMREAD.
        step("abort_memadr", LW, 3'b010, 1'b0, 1'b0, E_MA);
        op = LW; funct3 = 3'b010;
        #1;
        expect_now("abort_memread", E_MR);
        reset = 1'b1;
        #1;
        expect_now("abort_async_fetch", E_F);
        @(posedge clk);
        #1;
        expect_now("abort_held_fetch", E_F);
        reset = 1'b0;
        step("abort_restart_fetch", LW, 3'b010, 1'b0, 1'b0, E_F);
        step("abort_restart_decode", LW, 3'b010, 1'b0, 1'b0, E_D);
        step("abort_restart_memadr", LW, 3'b010, 1'b0, 1'b0, E_MA);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
